// File: rtl/serial_parity_checker_pkg.sv
// Shared definitions for the XOR-parity serial link: receiver FSM states,
// parity sense constants and error counter width.
package serial_parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/serial_parity_checker_if.sv
// Bit-serial input and decoded-word output bundle of the parity checker.
// Carries err_cnt only when SERIAL_PARITY_CHECKER_ERR_CNT_EN is defined.
interface serial_parity_checker_if #(
  parameter int DATA_W = 8
);
  import serial_parity_pkg::*;

  logic              bit_valid;
  logic              bit_in;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              parity_err;
  logic              frame_err;
  logic              busy;
`ifdef SERIAL_PARITY_CHECKER_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    output bit_valid, bit_in,
    input  data_out, data_valid, parity_err, frame_err, busy, err_cnt
  );
  modport slave (
    input  bit_valid, bit_in,
    output data_out, data_valid, parity_err, frame_err, busy, err_cnt
  );
`else
  modport master (
    output bit_valid, bit_in,
    input  data_out, data_valid, parity_err, frame_err, busy
  );
  modport slave (
    input  bit_valid, bit_in,
    output data_out, data_valid, parity_err, frame_err, busy
  );
`endif

endinterface

// File: rtl/serial_parity_checker_parity_accum.sv
// One-bit running XOR accumulator with clear and enable; shared with the
// matching parity generator.
module parity_accum (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic d,
  output logic q
);

  logic q_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q_reg <= 1'b0;
    end else if (en) begin
      q_reg <= q_reg ^ d;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/serial_parity_checker.sv
// Receiver for start / DATA_W LSB-first data / parity / stop frames.
// Optional saturating error counter via SERIAL_PARITY_CHECKER_ERR_CNT_EN.
module serial_parity_checker
  import serial_parity_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ODD_PARITY = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  serial_parity_checker_if.slave link
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);
  localparam logic ODD_BIT = (ODD_PARITY != 0) ? PARITY_ODD : PARITY_EVEN;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic [DATA_W-1:0] shift_reg;
  logic              err_pending_reg;
  logic [DATA_W-1:0] data_out_reg;
  logic              data_valid_reg;
  logic              parity_err_reg;
  logic              frame_err_reg;

  logic acc_clr, acc_en, acc_q;
  logic data_hit, parity_hit, stop_hit;

  parity_accum u_parity_accum (
    .clk (clk),
    .rst (rst),
    .clr (acc_clr),
    .en  (acc_en),
    .d   (link.bit_in),
    .q   (acc_q)
  );

  always_comb begin
    state_next = state_reg;
    acc_clr    = 1'b0;
    acc_en     = 1'b0;
    data_hit   = 1'b0;
    parity_hit = 1'b0;
    stop_hit   = 1'b0;
    if (link.bit_valid) begin
      case (state_reg)
        IDLE: begin
          if (!link.bit_in) begin
            state_next = DATA;
            acc_clr    = 1'b1;
          end
        end
        DATA: begin
          acc_en   = 1'b1;
          data_hit = 1'b1;
          if (cnt_reg == LAST_IDX) begin
            state_next = PARITY;
          end
        end
        PARITY: begin
          parity_hit = 1'b1;
          state_next = STOP;
        end
        STOP: begin
          stop_hit   = 1'b1;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // The counter restarts on every accepted start bit, so it never needs to wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg         <= '0;
      shift_reg       <= '0;
      err_pending_reg <= 1'b0;
      data_out_reg    <= '0;
      data_valid_reg  <= 1'b0;
      parity_err_reg  <= 1'b0;
      frame_err_reg   <= 1'b0;
    end else begin
      data_valid_reg <= 1'b0;
      if (acc_clr) begin
        cnt_reg <= '0;
      end
      if (data_hit) begin
        shift_reg[cnt_reg] <= link.bit_in;
        if (cnt_reg != LAST_IDX) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
      if (parity_hit) begin
        err_pending_reg <= acc_q ^ link.bit_in ^ ODD_BIT;
      end
      if (stop_hit) begin
        data_out_reg   <= shift_reg;
        parity_err_reg <= err_pending_reg;
        frame_err_reg  <= ~link.bit_in;
        data_valid_reg <= 1'b1;
      end
    end
  end

`ifdef SERIAL_PARITY_CHECKER_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_reg <= '0;
    end else if (stop_hit && (err_pending_reg || !link.bit_in) && (err_cnt_reg != '1)) begin
      err_cnt_reg <= err_cnt_reg + 1'b1;
    end
  end

  assign link.err_cnt = err_cnt_reg;
`endif

  assign link.data_out   = data_out_reg;
  assign link.data_valid = data_valid_reg;
  assign link.parity_err = parity_err_reg;
  assign link.frame_err  = frame_err_reg;
  assign link.busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_serial_parity_checker.sv
// Self-checking bench: even- and odd-parity checkers fed the same bit stream,
// table-driven frames plus hand sequences, scoreboard checked on data_valid.
module tb_serial_parity_checker;

  logic clk;
  logic rst;

  serial_parity_checker_if #(.DATA_W(8)) link_even ();
  serial_parity_checker_if #(.DATA_W(8)) link_odd ();

  assign link_odd.bit_valid = link_even.bit_valid;
  assign link_odd.bit_in    = link_even.bit_in;

  serial_parity_checker #(.DATA_W(8), .ODD_PARITY(0)) dut_even (
    .clk  (clk),
    .rst  (rst),
    .link (link_even)
  );

  serial_parity_checker #(.DATA_W(8), .ODD_PARITY(1)) dut_odd (
    .clk  (clk),
    .rst  (rst),
    .link (link_odd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       perr_even;
    logic       perr_odd;
    logic       ferr;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    bit         gappy;
  } vec_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         n_frames = 0;
  logic [7:0] last_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input bit gappy);
    link_even.bit_valid = 1'b1;
    link_even.bit_in    = b;
    tick();
    if (gappy) begin
      link_even.bit_valid = 1'b0;
      link_even.bit_in    = 1'($urandom);
      tick();
    end
  endtask

  task automatic idle_gap(input int n);
    link_even.bit_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      link_even.bit_in = 1'($urandom);
      tick();
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input bit gappy);
    exp_t e;
    logic x;
    x           = (^d) ^ p;
    e.data      = d;
    e.perr_even = x;
    e.perr_odd  = ~x;
    e.ferr      = ~s;
    sb.push_back(e);
    last_data = d;
    send_bit(1'b0, gappy);
    check("busy_after_start", link_even.busy, 1);
    for (int i = 0; i < 8; i++) begin
      send_bit(d[i], gappy);
      if (gappy && i == 3) idle_gap(7);
    end
    send_bit(p, gappy);
    send_bit(s, gappy);
    link_even.bit_valid = 1'b0;
  endtask

  // Scoreboard consumer: every data_valid pulse must match the oldest queued frame.
  always @(negedge clk) begin
    if (!rst && (link_even.data_valid || link_odd.data_valid)) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pulse: got data_valid=1 data=0x%0h, expected no pulse",
                 link_even.data_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        n_frames++;
        check("even_valid", link_even.data_valid, 1);
        check("odd_valid", link_odd.data_valid, 1);
        check("data_out", link_even.data_out, e.data);
        check("odd_data_out", link_odd.data_out, e.data);
        check("parity_err_even", link_even.parity_err, e.perr_even);
        check("parity_err_odd", link_odd.parity_err, e.perr_odd);
        check("frame_err", link_even.frame_err, e.ferr);
        check("odd_frame_err", link_odd.frame_err, e.ferr);
        $display("frame %0d: data=0x%02h perr_even=%b perr_odd=%b ferr=%b",
                 n_frames, link_even.data_out, link_even.parity_err,
                 link_odd.parity_err, link_even.frame_err);
      end
    end
  end

  vec_t vecs[7];

  initial begin
    vecs[0] = '{data: 8'hA5, par: 1'b0, stop: 1'b1, gappy: 1'b0};
    vecs[1] = '{data: 8'hA5, par: 1'b1, stop: 1'b1, gappy: 1'b0};
    vecs[2] = '{data: 8'h3C, par: 1'b0, stop: 1'b0, gappy: 1'b0};
    vecs[3] = '{data: 8'h01, par: 1'b1, stop: 1'b1, gappy: 1'b0};
    vecs[4] = '{data: 8'hFF, par: 1'b0, stop: 1'b1, gappy: 1'b1};
    vecs[5] = '{data: 8'h80, par: 1'b0, stop: 1'b0, gappy: 1'b0};
    vecs[6] = '{data: 8'h00, par: 1'b0, stop: 1'b1, gappy: 1'b0};

    rst = 1'b1;
    link_even.bit_valid = 1'($urandom);
    link_even.bit_in    = 1'($urandom);
    tick();
    link_even.bit_valid = 1'($urandom);
    link_even.bit_in    = 1'($urandom);
    tick();
    check("rst_data_out", link_even.data_out, 0);
    check("rst_data_valid", link_even.data_valid, 0);
    check("rst_parity_err", link_even.parity_err, 0);
    check("rst_frame_err", link_even.frame_err, 0);
    check("rst_busy", link_even.busy, 0);
`ifdef SERIAL_PARITY_CHECKER_ERR_CNT_EN
    check("rst_err_cnt", link_even.err_cnt, 0);
`endif
    rst = 1'b0;

    for (int k = 0; k < 5; k++) begin
      link_even.bit_valid = 1'b1;
      link_even.bit_in    = 1'b1;
      tick();
      check("idle_no_valid", link_even.data_valid, 0);
      check("idle_busy", link_even.busy, 0);
    end
    link_even.bit_valid = 1'b0;

    // Back-to-back: each frame starts on the first cycle after the previous stop bit.
    for (int v = 0; v < 7; v++) begin
      send_frame(vecs[v].data, vecs[v].par, vecs[v].stop, vecs[v].gappy);
      check("busy_after_stop", link_even.busy, 0);
    end

    idle_gap(3);
    check("data_out_hold", link_even.data_out, last_data);
    check("frames_seen", n_frames, 7);

    // Abort a frame after four data bits; the partial frame must vanish.
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(i & 1), 1'b0);
    check("busy_mid_frame", link_even.busy, 1);
    rst = 1'b1;
    link_even.bit_valid = 1'b1;
    link_even.bit_in    = 1'b1;
    tick();
    rst = 1'b0;
    link_even.bit_valid = 1'b0;
    check("abort_busy", link_even.busy, 0);
    check("abort_data_out", link_even.data_out, 0);
    check("abort_valid", link_even.data_valid, 0);
`ifdef SERIAL_PARITY_CHECKER_ERR_CNT_EN
    check("abort_err_cnt", link_even.err_cnt, 0);
`endif
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    idle_gap(2);
    check("after_abort_frames", n_frames, 8);

`ifdef SERIAL_PARITY_CHECKER_ERR_CNT_EN
    for (int f = 0; f < 300; f++) begin
      logic [7:0] d;
      d = 8'($urandom);
      send_frame(d, ~(^d), 1'b1, 1'b0);
      if (f == 9) begin
        idle_gap(1);
        check("err_cnt_10", link_even.err_cnt, 10);
      end
    end
    idle_gap(2);
    check("err_cnt_sat", link_even.err_cnt, 255);
`endif

    idle_gap(4);
    check("sb_drained", sb.size(), 0);
    check("data_out_final", link_even.data_out, last_data);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
